controlador_vendas: RTL and testbench
=====================================

CONTROLADOR_VENDAS -- requirements
Module: controlador_vendas

Interface
REQ-001 Parameter TIMEOUT, default 1000: idle cycles with nonzero credit before automatic refund; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 moeda_valida  input  1  one-cycle coin-inserted strobe.
REQ-005 moeda_tipo  input  2  coin code: 00=R$0,25 (1 unit), 01=R$0,50 (2), 10=R$1,00 (4), 11=invalid.
REQ-006 selecionar  input  1  one-cycle product-select strobe.
REQ-007 codigo_produto  input  4  product code, sampled with selecionar.
REQ-008 cancelar  input  1  one-cycle cancel/refund strobe.
REQ-009 codigo_consulta  output  4  code driven to price memory.
REQ-010 valor_preco  input  4  price from memory, in R$0,25 units.
REQ-011 produto_existe  input  1  product-valid flag from memory.
REQ-012 credito  output  4  current credit, R$0,25 units.
REQ-013 liberar_produto  output  1  one-cycle dispense pulse.
REQ-014 produto_liberado  output  4  code of dispensed product; valid while liberar_produto=1.
REQ-015 troco  output  4  change amount; valid while troco_valido=1.
REQ-016 troco_valido  output  1  one-cycle change pulse.
REQ-017 moeda_rejeitada  output  1  one-cycle coin-returned pulse.
REQ-018 erro_produto  output  1  one-cycle nonexistent-product pulse.
REQ-019 credito_insuficiente  output  1  one-cycle insufficient-credit pulse.

Function
REQ-020 FSM states SHALL be ESPERA, CONSULTA, VERIFICA, LIBERA, TROCO; all outputs SHALL be registered.
REQ-021 ESPERA, priority per cycle: cancelar > selecionar > moeda_valida.
REQ-022 ESPERA + cancelar: credito>0 -> TROCO; credito=0 -> stay ESPERA, no pulse.
REQ-023 ESPERA + selecionar (no cancelar): latch codigo_produto into internal code register, go CONSULTA.
REQ-024 ESPERA + moeda_valida alone: valid coin with credito+value<=15 adds value; moeda_tipo=11 or sum>15 -> moeda_rejeitada, credito unchanged.
REQ-025 moeda_valida in any state other than ESPERA, or coincident with selecionar/cancelar, SHALL give moeda_rejeitada and no credit change.
REQ-026 codigo_consulta SHALL equal the latched code from CONSULTA through LIBERA; memory is combinational and settles within CONSULTA.
REQ-027 CONSULTA: register valor_preco and produto_existe, go VERIFICA (exactly one cycle).
REQ-028 VERIFICA: !existe -> erro_produto, ESPERA; existe and credito<preco -> credito_insuficiente, ESPERA; otherwise LIBERA; credito unchanged in both error cases.
REQ-029 LIBERA: liberar_produto=1, produto_liberado=latched code, credito-=preco; go TROCO if remainder>0 else ESPERA.
REQ-030 TROCO: troco=credito, troco_valido=1, credito=0, go ESPERA (exactly one cycle).
REQ-031 Latency: liberar_produto SHALL assert 3 cycles after the edge that samples selecionar; troco_valido 1 cycle after liberar_produto.
REQ-032 selecionar/cancelar outside ESPERA SHALL be ignored.
REQ-033 Idle counter (16 bit) SHALL count ESPERA cycles with credito>0 and no strobe; cleared by any strobe, credito=0 or leaving ESPERA.
REQ-034 Counter reaching TIMEOUT-1 SHALL force TROCO on the next edge, refunding full credit.
REQ-035 Arithmetic SHALL be 4-bit unsigned; credit never wraps (REQ-024 guarantees).
REQ-036 troco and produto_liberado SHALL read 0 when their strobe is low.

Reset
REQ-037 reset=1 SHALL immediately force ESPERA, credito=0, counter=0, code register=0, all pulses and data outputs 0, codigo_consulta=0, regardless of clock.
REQ-038 Reset mid-transaction (any state) SHALL abort with no dispense and no change pulse; credit is lost.

Verification
REQ-039 Coins 10,01 (credito=6), select 0101 with price 2 -> liberar_produto at +3 cycles, produto_liberado=0101, next cycle troco=4, then credito=0.
REQ-040 credito=4, select 0000 price 4 -> liberar_produto, no troco_valido, credito=0, back to ESPERA.
REQ-041 credito=2, select 0001 (produto_existe=0) -> erro_produto once, credito=2; then select 0000 price 4 -> credito_insuficiente once, credito=2.
REQ-042 credito=12, coin 10 -> moeda_rejeitada, credito=12; coin 11 -> moeda_rejeitada; coin during CONSULTA -> moeda_rejeitada.
REQ-043 TIMEOUT=5, credito=3, no input -> troco=3 with troco_valido after idle count expires; selecionar+cancelar same cycle -> refund only.
REQ-044 Assert reset during LIBERA cycle -> outputs 0 immediately, no troco_valido afterwards, credito=0.

Source files
------------

// File: rtl/controlador_vendas.sv
// Vending-machine sales controller.
// Accepts coins into a 4-bit credit (R$0,25 units) and looks up the selected product's price
// in an external combinational memory. It then dispenses the product, returns change, or
// refunds on cancel or on idle timeout. All outputs come straight from registers.
//
// Handshake: every input strobe is a single-cycle pulse. It is sampled on the rising edge
// where it is high. Every output pulse is high for exactly one cycle. Its data output
// (produto_liberado, troco) is meaningful only while that pulse is high and reads 0 otherwise.
module controlador_vendas #(
    parameter int TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       moeda_valida,
    input  logic [1:0] moeda_tipo,
    input  logic       selecionar,
    input  logic [3:0] codigo_produto,
    input  logic       cancelar,
    output logic [3:0] codigo_consulta,
    input  logic [3:0] valor_preco,
    input  logic       produto_existe,
    output logic [3:0] credito,
    output logic       liberar_produto,
    output logic [3:0] produto_liberado,
    output logic [3:0] troco,
    output logic       troco_valido,
    output logic       moeda_rejeitada,
    output logic       erro_produto,
    output logic       credito_insuficiente,
    output logic [2:0] estado_dbg
);

    localparam logic [2:0] ESPERA   = 3'd0;
    localparam logic [2:0] CONSULTA = 3'd1;
    localparam logic [2:0] VERIFICA = 3'd2;
    localparam logic [2:0] LIBERA   = 3'd3;
    localparam logic [2:0] TROCO    = 3'd4;

    // Last idle count before the automatic refund fires.
    localparam logic [15:0] LIMITE = 16'(TIMEOUT - 1);

    logic [2:0]  estado;
    logic [3:0]  codigo;
    logic [3:0]  preco;
    logic        existe;
    logic [15:0] ocioso;

    logic [4:0]  valor_moeda;
    logic [4:0]  soma;
    logic        moeda_ok;
    logic        strobe;

    assign codigo_consulta = codigo;
    assign estado_dbg      = estado;
    assign strobe          = moeda_valida | selecionar | cancelar;

    // Coin decode; the 5-bit sum detects credit overflow without wrapping.
    always_comb begin
        valor_moeda = 5'd0;
        case (moeda_tipo)
            2'b00:   valor_moeda = 5'd1;
            2'b01:   valor_moeda = 5'd2;
            2'b10:   valor_moeda = 5'd4;
            default: valor_moeda = 5'd0;
        endcase
        soma     = {1'b0, credito} + valor_moeda;
        moeda_ok = (moeda_tipo != 2'b11) && (soma <= 5'd15);
    end

    // Idle counter: only runs while waiting with credit and no strobe; wraps to 0 when the refund fires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ocioso <= 16'd0;
        end else if (estado == ESPERA && credito != 4'd0 && !strobe) begin
            ocioso <= (ocioso == LIMITE) ? 16'd0 : ocioso + 16'd1;
        end else begin
            ocioso <= 16'd0;
        end
    end

    // Main sales FSM with registered pulses and data outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado               <= ESPERA;
            credito              <= 4'd0;
            codigo               <= 4'd0;
            preco                <= 4'd0;
            existe               <= 1'b0;
            liberar_produto      <= 1'b0;
            produto_liberado     <= 4'd0;
            troco                <= 4'd0;
            troco_valido         <= 1'b0;
            moeda_rejeitada      <= 1'b0;
            erro_produto         <= 1'b0;
            credito_insuficiente <= 1'b0;
        end else begin
            liberar_produto      <= 1'b0;
            produto_liberado     <= 4'd0;
            troco                <= 4'd0;
            troco_valido         <= 1'b0;
            erro_produto         <= 1'b0;
            credito_insuficiente <= 1'b0;
            // A coin that cannot be accepted this cycle is handed straight back.
            moeda_rejeitada      <= moeda_valida &&
                                    (estado != ESPERA || selecionar || cancelar);

            case (estado)
                ESPERA: begin
                    if (cancelar) begin
                        if (credito != 4'd0) estado <= TROCO;
                    end else if (selecionar) begin
                        codigo <= codigo_produto;
                        estado <= CONSULTA;
                    end else if (moeda_valida) begin
                        if (moeda_ok) credito <= soma[3:0];
                        else          moeda_rejeitada <= 1'b1;
                    end else if (credito != 4'd0 && ocioso == LIMITE) begin
                        estado <= TROCO;
                    end
                end
                CONSULTA: begin
                    preco  <= valor_preco;
                    existe <= produto_existe;
                    estado <= VERIFICA;
                end
                VERIFICA: begin
                    if (!existe) begin
                        erro_produto <= 1'b1;
                        estado       <= ESPERA;
                    end else if (credito < preco) begin
                        credito_insuficiente <= 1'b1;
                        estado               <= ESPERA;
                    end else begin
                        estado <= LIBERA;
                    end
                end
                LIBERA: begin
                    liberar_produto  <= 1'b1;
                    produto_liberado <= codigo;
                    credito          <= credito - preco;
                    estado           <= (credito != preco) ? TROCO : ESPERA;
                end
                TROCO: begin
                    troco        <= credito;
                    troco_valido <= 1'b1;
                    credito      <= 4'd0;
                    estado       <= ESPERA;
                end
                default: estado <= ESPERA;
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_vendas.sv
// Bench for controlador_vendas: directed scenarios with literal expectations, then random traffic.
// A transaction-level model plans each accepted request as a list of per-cycle output snapshots.
module tb_controlador_vendas;

    localparam int TIMEOUT = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       moeda_valida = 1'b0;
    logic [1:0] moeda_tipo = 2'd0;
    logic       selecionar = 1'b0;
    logic [3:0] codigo_produto = 4'd0;
    logic       cancelar = 1'b0;
    logic [3:0] codigo_consulta, valor_preco, credito, produto_liberado, troco;
    logic       produto_existe, liberar_produto, troco_valido, moeda_rejeitada;
    logic       erro_produto, credito_insuficiente;
    logic [2:0] estado_dbg;

    // Combinational price memory.
    logic [3:0] rom_price [16];
    logic       rom_exist [16];
    assign valor_preco    = rom_price[codigo_consulta];
    assign produto_existe = rom_exist[codigo_consulta];

    controlador_vendas #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .moeda_valida(moeda_valida), .moeda_tipo(moeda_tipo),
        .selecionar(selecionar), .codigo_produto(codigo_produto), .cancelar(cancelar),
        .codigo_consulta(codigo_consulta), .valor_preco(valor_preco), .produto_existe(produto_existe),
        .credito(credito), .liberar_produto(liberar_produto), .produto_liberado(produto_liberado),
        .troco(troco), .troco_valido(troco_valido), .moeda_rejeitada(moeda_rejeitada),
        .erro_produto(erro_produto), .credito_insuficiente(credito_insuficiente),
        .estado_dbg(estado_dbg)
    );

    // ---------------- scoreboard ----------------
    int   n_checks = 0;
    int   n_errors = 0;
    logic chk_en = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Snapshot layout: {lib, prod[3:0], tv, tr[3:0], erro, insuf, cred[3:0]}
    logic [15:0] exp_q [$];
    logic [15:0] s_model;
    int          m_credit = 0;
    int          m_idle = 0;
    logic [3:0]  m_code = 4'd0;
    logic [3:0]  e_credit = 4'd0, e_prod = 4'd0, e_tr = 4'd0, e_code = 4'd0;
    logic        e_lib = 1'b0, e_tv = 1'b0, e_rej = 1'b0, e_erro = 1'b0, e_insuf = 1'b0;

    function automatic logic [15:0] pack(input logic lib, input logic [3:0] prod, input logic tv,
                                         input logic [3:0] tr, input logic er, input logic ins,
                                         input int cred);
        return {lib, prod, tv, tr, er, ins, 4'(cred)};
    endfunction

    task automatic plan_refund();
        exp_q.push_back(pack(1'b0, 4'd0, 1'b1, 4'(m_credit), 1'b0, 1'b0, 0));
    endtask

    // A purchase: lookup cycle, decision cycle, then dispense and change if affordable.
    task automatic plan_purchase(input logic [3:0] code);
        int p;
        int c;
        p = int'(rom_price[code]);
        c = m_credit;
        exp_q.push_back(pack(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, c));
        if (!rom_exist[code]) begin
            exp_q.push_back(pack(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, c));
        end else if (c < p) begin
            exp_q.push_back(pack(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, c));
        end else begin
            exp_q.push_back(pack(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, c));
            exp_q.push_back(pack(1'b1, code, 1'b0, 4'd0, 1'b0, 1'b0, c - p));
            if (c - p > 0) exp_q.push_back(pack(1'b0, 4'd0, 1'b1, 4'(c - p), 1'b0, 1'b0, 0));
        end
    endtask

    // Reference model: what the outputs must read after each edge.
    always @(posedge clk or posedge reset) begin
        e_lib = 1'b0; e_prod = 4'd0; e_tv = 1'b0; e_tr = 4'd0;
        e_rej = 1'b0; e_erro = 1'b0; e_insuf = 1'b0;
        if (reset) begin
            exp_q.delete();
            m_credit = 0;
            m_idle   = 0;
            m_code   = 4'd0;
        end else begin
            if (exp_q.size() != 0) begin
                s_model  = exp_q.pop_front();
                e_lib    = s_model[15];
                e_prod   = s_model[14:11];
                e_tv     = s_model[10];
                e_tr     = s_model[9:6];
                e_erro   = s_model[5];
                e_insuf  = s_model[4];
                m_credit = int'(s_model[3:0]);
                e_rej    = moeda_valida;
                m_idle   = 0;
            end else if (cancelar) begin
                e_rej = moeda_valida;
                if (m_credit > 0) plan_refund();
                m_idle = 0;
            end else if (selecionar) begin
                e_rej  = moeda_valida;
                m_code = codigo_produto;
                plan_purchase(codigo_produto);
                m_idle = 0;
            end else if (moeda_valida) begin
                if (moeda_tipo == 2'b11 || m_credit + (1 << moeda_tipo) > 15) e_rej = 1'b1;
                else m_credit = m_credit + (1 << moeda_tipo);
                m_idle = 0;
            end else if (m_credit > 0) begin
                m_idle++;
                if (m_idle == TIMEOUT) begin
                    plan_refund();
                    m_idle = 0;
                end
            end else begin
                m_idle = 0;
            end
        end
        e_credit = 4'(m_credit);
        e_code   = m_code;
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("credito", credito, e_credit);
            check("liberar_produto", liberar_produto, e_lib);
            check("produto_liberado", produto_liberado, e_prod);
            check("troco_valido", troco_valido, e_tv);
            check("troco", troco, e_tr);
            check("moeda_rejeitada", moeda_rejeitada, e_rej);
            check("erro_produto", erro_produto, e_erro);
            check("credito_insuficiente", credito_insuficiente, e_insuf);
            check("codigo_consulta", codigo_consulta, e_code);
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge; holds the inputs across one rising edge and returns at the next falling edge.
    task automatic step(input logic mv, input logic [1:0] mt, input logic sel,
                        input logic [3:0] cod, input logic can);
        moeda_valida   = mv;
        moeda_tipo     = mt;
        selecionar     = sel;
        codigo_produto = cod;
        cancelar       = can;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 2'b00, 1'b0, 4'd0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 16; i++) begin
            rom_price[i] = 4'($urandom_range(1, 15));
            rom_exist[i] = ($urandom_range(0, 3) != 0);
        end
        rom_price[0] = 4'd4; rom_exist[0] = 1'b1;
        rom_price[1] = 4'd3; rom_exist[1] = 1'b0;
        rom_price[5] = 4'd2; rom_exist[5] = 1'b1;

        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_credito", credito, 0);
        check("rst_estado", estado_dbg, 0);
        check("rst_codigo", codigo_consulta, 0);
        check("rst_pulses", {liberar_produto, troco_valido, moeda_rejeitada, erro_produto, credito_insuficiente}, 0);
        reset = 1'b0;

        // Buy with change: 6 credit, price 2.
        step(1'b1, 2'b10, 1'b0, 4'd0, 1'b0);
        check("r039_cred4", credito, 4);
        step(1'b1, 2'b01, 1'b0, 4'd0, 1'b0);
        check("r039_cred6", credito, 6);
        step(1'b0, 2'b00, 1'b1, 4'b0101, 1'b0);
        check("r039_code", codigo_consulta, 5);
        idle(2);
        check("r039_lib_early", liberar_produto, 0);
        idle(1);
        check("r039_lib", liberar_produto, 1);
        check("r039_prod", produto_liberado, 5);
        check("r039_cred_after", credito, 4);
        idle(1);
        check("r039_tv", troco_valido, 1);
        check("r039_troco", troco, 4);
        check("r039_prod_zero", produto_liberado, 0);
        check("r039_cred0", credito, 0);

        // Exact payment: no change pulse.
        step(1'b1, 2'b10, 1'b0, 4'd0, 1'b0);
        step(1'b0, 2'b00, 1'b1, 4'b0000, 1'b0);
        idle(3);
        check("r040_lib", liberar_produto, 1);
        check("r040_cred", credito, 0);
        idle(1);
        check("r040_no_tv", troco_valido, 0);
        step(1'b1, 2'b00, 1'b0, 4'd0, 1'b0);
        check("r040_espera", credito, 1);
        step(1'b0, 2'b00, 1'b0, 4'd0, 1'b1);
        idle(1);
        check("r040_cancel_troco", troco, 1);

        // Nonexistent product, then insufficient credit.
        step(1'b1, 2'b01, 1'b0, 4'd0, 1'b0);
        step(1'b0, 2'b00, 1'b1, 4'b0001, 1'b0);
        idle(2);
        check("r041_erro", erro_produto, 1);
        check("r041_cred", credito, 2);
        idle(1);
        check("r041_erro_once", erro_produto, 0);
        step(1'b0, 2'b00, 1'b1, 4'b0000, 1'b0);
        idle(2);
        check("r041_insuf", credito_insuficiente, 1);
        check("r041_cred2", credito, 2);
        idle(1);
        check("r041_insuf_once", credito_insuficiente, 0);

        // Coin rejection: overflow, invalid code, coin while busy.
        step(1'b1, 2'b10, 1'b0, 4'd0, 1'b0);
        step(1'b1, 2'b10, 1'b0, 4'd0, 1'b0);
        step(1'b1, 2'b01, 1'b0, 4'd0, 1'b0);
        check("r042_cred12", credito, 12);
        step(1'b1, 2'b10, 1'b0, 4'd0, 1'b0);
        check("r042_rej_ovf", moeda_rejeitada, 1);
        check("r042_cred_kept", credito, 12);
        step(1'b1, 2'b11, 1'b0, 4'd0, 1'b0);
        check("r042_rej_inv", moeda_rejeitada, 1);
        step(1'b0, 2'b00, 1'b1, 4'b0000, 1'b0);
        step(1'b1, 2'b00, 1'b0, 4'd0, 1'b0);
        check("r042_rej_busy", moeda_rejeitada, 1);
        check("r042_cred_busy", credito, 12);
        idle(3);
        check("r042_troco", troco, 8);

        // Idle timeout refund, then select+cancel together refunds only.
        step(1'b1, 2'b01, 1'b0, 4'd0, 1'b0);
        step(1'b1, 2'b00, 1'b0, 4'd0, 1'b0);
        idle(5);
        check("r043_no_tv_yet", troco_valido, 0);
        check("r043_cred3", credito, 3);
        idle(1);
        check("r043_tv", troco_valido, 1);
        check("r043_troco", troco, 3);
        step(1'b1, 2'b10, 1'b0, 4'd0, 1'b0);
        step(1'b0, 2'b00, 1'b1, 4'b0101, 1'b1);
        check("r043_code_kept", codigo_consulta, 0);
        idle(1);
        check("r043_refund", troco, 4);
        check("r043_no_lib", liberar_produto, 0);
        idle(2);

        // Reset during dispense cycle.
        step(1'b1, 2'b10, 1'b0, 4'd0, 1'b0);
        step(1'b1, 2'b10, 1'b0, 4'd0, 1'b0);
        step(1'b0, 2'b00, 1'b1, 4'b0101, 1'b0);
        idle(2);
        #2 reset = 1'b1;
        #1;
        check("r044_cred", credito, 0);
        check("r044_code", codigo_consulta, 0);
        check("r044_estado", estado_dbg, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idle(1);
            check("r044_no_tv", troco_valido, 0);
            check("r044_no_lib", liberar_produto, 0);
        end

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                moeda_valida = 1'b0;
                selecionar   = 1'b0;
                cancelar     = 1'b0;
                #2 reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end else begin
                step($urandom_range(0, 99) < 35, 2'($urandom_range(0, 3)),
                     $urandom_range(0, 99) < 8, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 99) < 4);
            end
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
